// File: rtl/conv_clause_array.sv
// Convolution clause stage: one trained clause evaluated over a window
// stream on parallel PEs, with a registered forward path for chaining.
module conv_clause_array #(
  parameter int NUM_PE = 8,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int PATCH_MAX = 7,
  localparam int P2 = PATCH_MAX * PATCH_MAX,
  localparam int CLAUSE_W = 2 * (IMG_H + IMG_W + P2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    img_rst,
  input  logic [2:0]              cfg_patch_size,
  input  logic [CLAUSE_W-1:0]     clause_in,
  input  logic                    clause_valid,
  output logic                    clause_ready,
  input  logic                    win_valid,
  input  logic                    win_last,
  input  logic [NUM_PE-1:0]       win_pe_en,
  input  logic [NUM_PE*P2-1:0]    win_patch,
  input  logic [IMG_W-1:0]        win_x,
  input  logic [NUM_PE*IMG_H-1:0] win_y,
  input  logic                    prev_clause_op,
  output logic                    clause_op,
  output logic                    clause_done,
  output logic                    busy,
  output logic                    fwd_valid,
  output logic                    fwd_last,
  output logic [NUM_PE-1:0]       fwd_pe_en,
  output logic [NUM_PE*P2-1:0]    fwd_patch,
  output logic [IMG_W-1:0]        fwd_x,
  output logic [NUM_PE*IMG_H-1:0] fwd_y
);

  localparam int XO = IMG_H;
  localparam int YEO = IMG_H + IMG_W;
  localparam int XEO = 2 * IMG_H + IMG_W;
  localparam int LIO = 2 * (IMG_H + IMG_W);
  localparam int LEO = LIO + P2;

  typedef enum logic [1:0] {IDLE, ARMED, FLUSH, DONE} state_t;

  state_t state;
  logic [CLAUSE_W-1:0] clause_q;
  logic [2:0] ps_q;
  logic acc;
  logic flush_cnt;

  logic [IMG_H-1:0] y_inc, y_exc, ydc;
  logic [IMG_W-1:0] x_inc, x_exc, xdc;
  logic [P2-1:0] lit_inc, lit_exc, lit_dc;

  logic [NUM_PE-1:0] lit_hit;
  logic [NUM_PE-1:0] pe_hit;
  logic x_hit;
  logic beat_hit;

  logic s1_valid;
  logic [NUM_PE-1:0] s1_lit;
  logic [NUM_PE-1:0] s1_pe_en;
  logic [IMG_W-1:0] s1_x;
  logic [NUM_PE*IMG_H-1:0] s1_y;

  assign y_inc = clause_q[0 +: IMG_H];
  assign x_inc = clause_q[XO +: IMG_W];
  assign y_exc = clause_q[YEO +: IMG_H];
  assign x_exc = clause_q[XEO +: IMG_W];
  assign lit_inc = clause_q[LIO +: P2];
  assign lit_exc = clause_q[LEO +: P2];

  assign clause_ready = (state == IDLE);
  assign busy = (state != IDLE);

  // Don't-care masks for cells outside the active patch / positions
  always_comb begin
    lit_dc = '0;
    xdc = '0;
    ydc = '0;
    for (int r = 0; r < PATCH_MAX; r++)
      for (int c = 0; c < PATCH_MAX; c++)
        lit_dc[r*PATCH_MAX+c] = (r >= int'(ps_q)) || (c >= int'(ps_q));
    for (int i = 0; i < IMG_W; i++)
      xdc[i] = i > IMG_W - int'(ps_q);
    for (int i = 0; i < IMG_H; i++)
      ydc[i] = i > IMG_H - int'(ps_q);
  end

  // Stage-1 literal match per PE
  always_comb begin
    lit_hit = '0;
    for (int k = 0; k < NUM_PE; k++)
      lit_hit[k] =
        (&(win_patch[k*P2 +: P2] | ~lit_inc | lit_dc)) &
        (&(~win_patch[k*P2 +: P2] | ~lit_exc | lit_dc));
  end

  // Stage-2 position match and beat result
  always_comb begin
    pe_hit = '0;
    for (int k = 0; k < NUM_PE; k++)
      pe_hit[k] = s1_pe_en[k] & s1_lit[k] &
        (&(s1_y[k*IMG_H +: IMG_H] | ~y_inc | ydc)) &
        (&(~s1_y[k*IMG_H +: IMG_H] | ~y_exc | ydc));
    x_hit = (&(s1_x | ~x_inc | xdc)) & (&(~s1_x | ~x_exc | xdc));
    beat_hit = s1_valid & x_hit & (|pe_hit);
  end

  // Stage-1 valid; only beats seen while armed enter the pipe
  always_ff @(posedge clk) begin
    if (rst || img_rst) s1_valid <= 1'b0;
    else s1_valid <= win_valid && (state == ARMED);
  end

  // Stage-1 data registers
  always_ff @(posedge clk) begin
    s1_lit <= lit_hit;
    s1_pe_en <= win_pe_en;
    s1_x <= win_x;
    s1_y <= win_y;
  end

  // Clause sequencing FSM and OR accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      clause_q <= '0;
      ps_q <= '0;
      acc <= 1'b0;
      flush_cnt <= 1'b0;
      clause_op <= 1'b0;
      clause_done <= 1'b0;
    end else if (img_rst) begin
      state <= IDLE;
      acc <= 1'b0;
      flush_cnt <= 1'b0;
      clause_op <= 1'b0;
      clause_done <= 1'b0;
    end else begin
      clause_done <= 1'b0;
      clause_op <= 1'b0;
      if (beat_hit) acc <= 1'b1;
      unique case (state)
        IDLE: begin
          if (clause_valid) begin
            clause_q <= clause_in;
            if (cfg_patch_size == 3'd0 || int'(cfg_patch_size) > PATCH_MAX)
              ps_q <= 3'(PATCH_MAX);
            else
              ps_q <= cfg_patch_size;
            state <= ARMED;
          end
        end
        ARMED: begin
          if (win_valid && win_last) begin
            state <= FLUSH;
            flush_cnt <= 1'b0;
          end
        end
        FLUSH: begin
          if (flush_cnt) begin
            state <= DONE;
            clause_done <= 1'b1;
            clause_op <= acc | beat_hit | prev_clause_op;
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          acc <= 1'b0;
        end
      endcase
    end
  end

  // Forward path: one-cycle copy of the window stream
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid <= 1'b0;
      fwd_last <= 1'b0;
      fwd_pe_en <= '0;
      fwd_patch <= '0;
      fwd_x <= '0;
      fwd_y <= '0;
    end else begin
      fwd_valid <= win_valid;
      fwd_last <= win_last;
      fwd_pe_en <= win_pe_en;
      fwd_patch <= win_patch;
      fwd_x <= win_x;
      fwd_y <= win_y;
    end
  end

endmodule

// File: tb/tb_conv_clause_array.sv
// Directed bench for conv_clause_array: single-beat vector table plus
// sequences for accumulation, image abort and clause-load blocking.
module tb_conv_clause_array;

  localparam int NPE = 8;
  localparam int W = 32;
  localparam int H = 32;
  localparam int P2 = 49;
  localparam int CW = 2 * (H + W + P2);

  logic clk = 1'b0;
  logic rst, img_rst;
  logic [2:0] cfg_patch_size;
  logic [CW-1:0] clause_in;
  logic clause_valid, clause_ready;
  logic win_valid, win_last;
  logic [NPE-1:0] win_pe_en;
  logic [NPE*P2-1:0] win_patch;
  logic [W-1:0] win_x;
  logic [NPE*H-1:0] win_y;
  logic prev_clause_op;
  logic clause_op, clause_done, busy;
  logic fwd_valid, fwd_last;
  logic [NPE-1:0] fwd_pe_en;
  logic [NPE*P2-1:0] fwd_patch;
  logic [W-1:0] fwd_x;
  logic [NPE*H-1:0] fwd_y;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  conv_clause_array dut (
    .clk(clk), .rst(rst), .img_rst(img_rst),
    .cfg_patch_size(cfg_patch_size), .clause_in(clause_in),
    .clause_valid(clause_valid), .clause_ready(clause_ready),
    .win_valid(win_valid), .win_last(win_last), .win_pe_en(win_pe_en),
    .win_patch(win_patch), .win_x(win_x), .win_y(win_y),
    .prev_clause_op(prev_clause_op), .clause_op(clause_op),
    .clause_done(clause_done), .busy(busy),
    .fwd_valid(fwd_valid), .fwd_last(fwd_last), .fwd_pe_en(fwd_pe_en),
    .fwd_patch(fwd_patch), .fwd_x(fwd_x), .fwd_y(fwd_y)
  );

  typedef struct {
    logic [2:0] ps;
    logic [CW-1:0] cl;
    logic [P2-1:0] patch;
    logic [W-1:0] x;
    logic [H-1:0] y;
    logic [NPE-1:0] pe_en;
    logic prev;
    logic exp;
  } vec_t;

  vec_t vt[20];

  function automatic logic [CW-1:0] mk(
    input logic [P2-1:0] le, input logic [P2-1:0] li,
    input logic [W-1:0] xe, input logic [H-1:0] ye,
    input logic [W-1:0] xi, input logic [H-1:0] yi);
    return {le, li, xe, ye, xi, yi};
  endfunction

  function automatic logic [P2-1:0] pb(input int i);
    logic [P2-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] wb(input int i);
    logic [31:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [CW-1:0] cl, input logic [2:0] ps);
    @(negedge clk);
    cfg_patch_size = ps;
    clause_in = cl;
    clause_valid = 1'b1;
    @(negedge clk);
    clause_valid = 1'b0;
  endtask

  // Drive one beat for a cycle; returns at the negedge after it was sampled
  task automatic beat(input logic v, input logic l, input logic [P2-1:0] p,
                      input logic [W-1:0] x, input logic [H-1:0] y,
                      input logic [NPE-1:0] en);
    win_valid = v;
    win_last = l;
    win_patch = {NPE{p}};
    win_x = x;
    win_y = {NPE{y}};
    win_pe_en = en;
    @(negedge clk);
    win_valid = 1'b0;
    win_last = 1'b0;
  endtask

  // Called at the negedge one cycle after the last beat was sampled
  task automatic wait_done(input string nm, input logic exp);
    int k;
    k = 1;
    while (!clause_done && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_lat"}, 64'(k), 64'd3);
    chk({nm, "_op"}, 64'(clause_op), 64'(exp));
    @(negedge clk);
    chk({nm, "_pulse"}, 64'(clause_done), 64'd0);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    prev_clause_op = v.prev;
    load(v.cl, v.ps);
    chk($sformatf("v%0d_busy", id), 64'(busy), 64'd1);
    beat(1'b1, 1'b1, v.patch, v.x, v.y, v.pe_en);
    wait_done($sformatf("v%0d", id), v.exp);
  endtask

  initial begin
    logic [CW-1:0] z, ca, cb, cx;
    int seen;
    z = '0;
    vt[0] = '{3'd3, z, '0, '0, '0, 8'h01, 1'b0, 1'b1};
    vt[1] = '{3'd3, mk('0, pb(0), '0, '0, '0, '0), '0, '0, '0, 8'hFF, 1'b0, 1'b0};
    vt[2] = '{3'd3, mk('0, pb(0), '0, '0, '0, '0), '0, '0, '0, 8'hFF, 1'b1, 1'b1};
    vt[3] = '{3'd5, mk('0, pb(6), '0, '0, '0, '0), '0, '0, '0, 8'hFF, 1'b0, 1'b1};
    vt[4] = '{3'd7, mk('0, pb(6), '0, '0, '0, '0), '0, '0, '0, 8'hFF, 1'b0, 1'b0};
    vt[5] = '{3'd3, mk('0, pb(0), '0, '0, '0, '0), pb(0), '0, '0, 8'h80, 1'b0, 1'b1};
    vt[6] = '{3'd3, mk(pb(0), pb(0), '0, '0, '0, '0), pb(0), '0, '0, 8'hFF, 1'b0, 1'b0};
    vt[7] = '{3'd3, mk(pb(0), pb(0), '0, '0, '0, '0), '0, '0, '0, 8'hFF, 1'b0, 1'b0};
    vt[8] = '{3'd3, z, '0, '0, '0, 8'h00, 1'b0, 1'b0};
    vt[9] = '{3'd0, mk('0, pb(6), '0, '0, '0, '0), '0, '0, '0, 8'hFF, 1'b0, 1'b0};
    vt[10] = '{3'd6, mk('0, pb(48), '0, '0, '0, '0), '0, '0, '0, 8'hFF, 1'b0, 1'b1};
    vt[11] = '{3'd5, mk('0, pb(35), '0, '0, '0, '0), '0, '0, '0, 8'hFF, 1'b0, 1'b1};
    vt[12] = '{3'd3, mk('0, '0, '0, '0, wb(3), '0), '0, 32'hF, '0, 8'hFF, 1'b0, 1'b1};
    vt[13] = '{3'd3, mk('0, '0, '0, '0, wb(3), '0), '0, 32'h7, '0, 8'hFF, 1'b0, 1'b0};
    vt[14] = '{3'd3, mk('0, '0, '0, '0, wb(31), '0), '0, '0, '0, 8'hFF, 1'b0, 1'b1};
    vt[15] = '{3'd1, mk('0, '0, '0, '0, wb(31), '0), '0, '0, '0, 8'hFF, 1'b0, 1'b0};
    vt[16] = '{3'd3, mk('0, '0, '0, '0, wb(29), '0), '0, '0, '0, 8'hFF, 1'b0, 1'b0};
    vt[17] = '{3'd3, mk('0, '0, '0, wb(2), '0, '0), '0, '0, 32'h4, 8'hFF, 1'b0, 1'b0};
    vt[18] = '{3'd3, mk('0, '0, '0, wb(2), '0, '0), '0, '0, 32'h0, 8'hFF, 1'b0, 1'b1};
    vt[19] = '{3'd3, mk('0, '0, '0, '0, '0, wb(30)), '0, '0, '0, 8'hFF, 1'b0, 1'b1};

    rst = 1'b1;
    img_rst = 1'b0;
    cfg_patch_size = 3'd3;
    clause_in = '0;
    clause_valid = 1'b0;
    win_valid = 1'b1;
    win_last = 1'b1;
    win_pe_en = 8'hFF;
    win_patch = '1;
    win_x = 32'h1234;
    win_y = '1;
    prev_clause_op = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(clause_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(clause_done), 64'd0);
    chk("rst_op", 64'(clause_op), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_fwd_x", 64'(fwd_x), 64'd0);
    rst = 1'b0;
    win_valid = 1'b0;
    win_last = 1'b0;
    @(negedge clk);
    chk("idle_ignores_win", 64'(busy), 64'd0);

    for (int i = 0; i < 20; i++) run_vec(i, vt[i]);

    // accumulation across beats: only the second beat matches
    cx = mk('0, '0, '0, '0, wb(3), '0);
    load(cx, 3'd3);
    beat(1'b1, 1'b0, '0, 32'h7, '0, 8'hFF);
    beat(1'b1, 1'b1, '0, 32'hF, '0, 8'hFF);
    wait_done("acc_second", 1'b1);
    // matching beat first, non-matching last still reports a match
    load(cx, 3'd3);
    beat(1'b1, 1'b0, '0, 32'hF, '0, 8'hFF);
    beat(1'b1, 1'b1, '0, 32'h7, '0, 8'hFF);
    wait_done("acc_first", 1'b1);
    // invalid matching beat contributes nothing
    load(cx, 3'd3);
    beat(1'b0, 1'b0, '0, 32'hF, '0, 8'hFF);
    beat(1'b1, 1'b1, '0, 32'h7, '0, 8'hFF);
    wait_done("acc_invalid", 1'b0);

    // image abort in either flush cycle drops the result
    for (int d = 0; d < 2; d++) begin
      load(z, 3'd3);
      beat(1'b1, 1'b1, '0, 32'h0, '0, 8'hFF);
      chk($sformatf("abort%0d_fwd_valid", d), 64'(fwd_valid), 64'd1);
      chk($sformatf("abort%0d_fwd_last", d), 64'(fwd_last), 64'd1);
      if (d == 1) @(negedge clk);
      img_rst = 1'b1;
      win_x = 32'hA5A5;
      @(negedge clk);
      img_rst = 1'b0;
      chk($sformatf("abort%0d_busy", d), 64'(busy), 64'd0);
      chk($sformatf("abort%0d_ready", d), 64'(clause_ready), 64'd1);
      chk($sformatf("abort%0d_done", d), 64'(clause_done), 64'd0);
      chk($sformatf("abort%0d_fwd_x", d), 64'(fwd_x), 64'hA5A5);
      seen = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (clause_done) seen++;
      end
      chk($sformatf("abort%0d_nodone", d), 64'(seen), 64'd0);
    end

    // clause offered while armed is held off until after DONE
    ca = z;
    cb = mk('0, pb(0), '0, '0, '0, '0);
    prev_clause_op = 1'b0;
    load(ca, 3'd3);
    clause_in = cb;
    clause_valid = 1'b1;
    @(negedge clk);
    chk("hold_ready", 64'(clause_ready), 64'd0);
    chk("hold_busy", 64'(busy), 64'd1);
    beat(1'b1, 1'b1, '0, '0, '0, 8'hFF);
    wait_done("hold_a", 1'b1);
    chk("hold_idle_ready", 64'(clause_ready), 64'd1);
    @(negedge clk);
    clause_valid = 1'b0;
    chk("hold_b_busy", 64'(busy), 64'd1);
    beat(1'b1, 1'b1, '0, '0, '0, 8'hFF);
    wait_done("hold_b", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
